// File: rtl/axi4lite_cmd_master.sv
// Single-outstanding AXI4-Lite master: turns one valid/ready command into an AW+W/B or AR/R
// transaction and returns the slave response on a valid/ready response port.
module axi4lite_cmd_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,

    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_write_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
    input  logic [STRB_WIDTH-1:0] cmd_wstrb_i,

    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic                  rsp_write_o,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic [1:0]            rsp_resp_o,

    output logic                  m_axi_awvalid_o,
    input  logic                  m_axi_awready_i,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr_o,
    output logic [2:0]            m_axi_awprot_o,

    output logic                  m_axi_wvalid_o,
    input  logic                  m_axi_wready_i,
    output logic [DATA_WIDTH-1:0] m_axi_wdata_o,
    output logic [STRB_WIDTH-1:0] m_axi_wstrb_o,

    input  logic                  m_axi_bvalid_i,
    output logic                  m_axi_bready_o,
    input  logic [1:0]            m_axi_bresp_i,

    output logic                  m_axi_arvalid_o,
    input  logic                  m_axi_arready_i,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr_o,
    output logic [2:0]            m_axi_arprot_o,

    input  logic                  m_axi_rvalid_i,
    output logic                  m_axi_rready_o,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata_i,
    input  logic [1:0]            m_axi_rresp_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_ADDR_DATA,
        S_WR_RESP,
        S_RD_ADDR,
        S_RD_DATA,
        S_RESP
    } state_t;

    state_t                state_q, state_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic                  write_q, write_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            resp_q, resp_d;
    logic                  aw_hs, w_hs;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            resp_q    <= 2'b00;
        end else begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
        end
    end

    // AW and W retire independently; the phase ends once both have handshaked.
    assign aw_hs = !aw_done_q && m_axi_awready_i;
    assign w_hs  = !w_done_q && m_axi_wready_i;

    always_comb begin
        state_d   = state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        write_d   = write_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    write_d   = cmd_write_i;
                    addr_d    = cmd_addr_i;
                    wdata_d   = cmd_wdata_i;
                    wstrb_d   = cmd_wstrb_i;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = cmd_write_i ? S_WR_ADDR_DATA : S_RD_ADDR;
                end
            end
            S_WR_ADDR_DATA: begin
                if (aw_hs) aw_done_d = 1'b1;
                if (w_hs)  w_done_d  = 1'b1;
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = S_WR_RESP;
            end
            S_WR_RESP: begin
                if (m_axi_bvalid_i) begin
                    resp_d  = m_axi_bresp_i;
                    rdata_d = '0;
                    state_d = S_RESP;
                end
            end
            S_RD_ADDR: begin
                if (m_axi_arready_i) state_d = S_RD_DATA;
            end
            S_RD_DATA: begin
                if (m_axi_rvalid_i) begin
                    resp_d  = m_axi_rresp_i;
                    rdata_d = m_axi_rdata_i;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign cmd_ready_o     = (state_q == S_IDLE);
    assign rsp_valid_o     = (state_q == S_RESP);
    assign rsp_write_o     = write_q;
    assign rsp_rdata_o     = rdata_q;
    assign rsp_resp_o      = resp_q;

    assign m_axi_awvalid_o = (state_q == S_WR_ADDR_DATA) && !aw_done_q;
    assign m_axi_awaddr_o  = addr_q;
    assign m_axi_awprot_o  = 3'b000;
    assign m_axi_wvalid_o  = (state_q == S_WR_ADDR_DATA) && !w_done_q;
    assign m_axi_wdata_o   = wdata_q;
    assign m_axi_wstrb_o   = wstrb_q;
    assign m_axi_bready_o  = (state_q == S_WR_RESP);
    assign m_axi_arvalid_o = (state_q == S_RD_ADDR);
    assign m_axi_araddr_o  = addr_q;
    assign m_axi_arprot_o  = 3'b000;
    assign m_axi_rready_o  = (state_q == S_RD_DATA);

endmodule

// File: tb/tb_axi4lite_cmd_master.sv
// Directed bench for axi4lite_cmd_master with a small AXI4-Lite slave model
// (4 words at 0x200-0x20C; partial strobes and other addresses answer SLVERR).
module tb_axi4lite_cmd_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic [2:0]  awprot, arprot;
    logic [1:0]  bresp, rresp;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi4lite_cmd_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
        .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_wstrb_i(cmd_wstrb),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_write_o(rsp_write),
        .rsp_rdata_o(rsp_rdata), .rsp_resp_o(rsp_resp),
        .m_axi_awvalid_o(awvalid), .m_axi_awready_i(awready), .m_axi_awaddr_o(awaddr),
        .m_axi_awprot_o(awprot),
        .m_axi_wvalid_o(wvalid), .m_axi_wready_i(wready), .m_axi_wdata_o(wdata),
        .m_axi_wstrb_o(wstrb),
        .m_axi_bvalid_i(bvalid), .m_axi_bready_o(bready), .m_axi_bresp_i(bresp),
        .m_axi_arvalid_o(arvalid), .m_axi_arready_i(arready), .m_axi_araddr_o(araddr),
        .m_axi_arprot_o(arprot),
        .m_axi_rvalid_i(rvalid), .m_axi_rready_o(rready), .m_axi_rdata_i(rdata),
        .m_axi_rresp_i(rresp)
    );

    // ---------------- slave model ----------------
    int          aw_delay = 0;
    int          aw_wait;
    logic        hold_r = 1'b0;
    logic [31:0] mem [0:3];
    logic        s_aw_got, s_w_got, r_pend;
    logic [31:0] s_awaddr, s_wdata, r_addr;
    logic [3:0]  s_wstrb;

    assign awready = (aw_wait >= aw_delay);
    assign wready  = 1'b1;
    assign arready = 1'b1;

    wire         aw_hs   = awvalid && awready;
    wire         w_hs    = wvalid && wready;
    wire         ar_hs   = arvalid && arready;
    wire  [31:0] e_awadr = aw_hs ? awaddr : s_awaddr;
    wire  [31:0] e_wdata = w_hs ? wdata : s_wdata;
    wire  [3:0]  e_wstrb = w_hs ? wstrb : s_wstrb;
    wire  [31:0] e_radr  = ar_hs ? araddr : r_addr;
    wire         wr_fire = (aw_hs || s_aw_got) && (w_hs || s_w_got) && !bvalid;

    function automatic logic addr_ok(input logic [31:0] a);
        return (a[31:4] == 28'h0000020) && (a[1:0] == 2'b00);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_wait  <= 0;
            s_aw_got <= 1'b0;
            s_w_got  <= 1'b0;
            s_awaddr <= '0;
            s_wdata  <= '0;
            s_wstrb  <= '0;
            bvalid   <= 1'b0;
            bresp    <= 2'b00;
            r_pend   <= 1'b0;
            r_addr   <= '0;
            rvalid   <= 1'b0;
            rdata    <= '0;
            rresp    <= 2'b00;
            for (int i = 0; i < 4; i++) mem[i] <= '0;
        end else begin
            aw_wait <= (awvalid && !awready) ? aw_wait + 1 : 0;
            if (aw_hs) begin s_aw_got <= 1'b1; s_awaddr <= awaddr; end
            if (w_hs)  begin s_w_got <= 1'b1; s_wdata <= wdata; s_wstrb <= wstrb; end
            if (bvalid && bready) begin
                bvalid <= 1'b0;
            end else if (wr_fire) begin
                bvalid   <= 1'b1;
                s_aw_got <= 1'b0;
                s_w_got  <= 1'b0;
                if (addr_ok(e_awadr) && e_wstrb == 4'hF) begin
                    mem[e_awadr[3:2]] <= e_wdata;
                    bresp <= 2'b00;
                end else begin
                    bresp <= 2'b10;
                end
            end
            if (ar_hs) begin r_pend <= 1'b1; r_addr <= araddr; end
            if (rvalid && rready) begin
                rvalid <= 1'b0;
                r_pend <= 1'b0;
            end else if ((ar_hs || r_pend) && !rvalid && !hold_r) begin
                rvalid <= 1'b1;
                r_pend <= 1'b0;
                rdata  <= addr_ok(e_radr) ? mem[e_radr[3:2]] : 32'h0;
                rresp  <= addr_ok(e_radr) ? 2'b00 : 2'b10;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_rsp(output logic [31:0] rd, output logic [1:0] rs, output logic rw,
                            output int lat);
        int n;
        n = 0;
        while (!rsp_valid && n < 100) begin @(posedge clk); #1; n++; end
        check("rsp_timeout", rsp_valid, 1'b1);
        rd  = rsp_rdata;
        rs  = rsp_resp;
        rw  = rsp_write;
        lat = n + 1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
        int n;
        cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 100) begin @(posedge clk); #1; n++; end
        check("cmd_accept", cmd_ready, 1'b1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic run_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] rd,
                           output logic [1:0] rs, output logic rw, output int lat);
        issue(w, a, d, s);
        wait_rsp(rd, rs, rw, lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0] rd;
        logic [1:0]  rs;
        logic        rw;
        int          lat, aw_cyc, w_cyc, b_first, stable, seen, n;

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valids", {awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 6'b0);
        check("reset_rsp_rdata", rsp_rdata, 32'h0);
        check("reset_rsp_resp", rsp_resp, 2'b00);
        check("reset_rsp_write", rsp_write, 1'b0);
        check("reset_awaddr", awaddr, 32'h0);
        check("reset_araddr", araddr, 32'h0);
        check("reset_wdata", wdata, 32'h0);
        check("reset_wstrb", wstrb, 4'h0);
        check("prot", {awprot, arprot}, 6'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("cmd_ready_after_reset", cmd_ready, 1'b1);

        // write then read back, zero-wait latency
        run_cmd(1'b1, 32'h0204, 32'hDEADBEEF, 4'hF, rd, rs, rw, lat);
        check("wr_rsp_write", rw, 1'b1);
        check("wr_resp", rs, 2'b00);
        check("wr_rdata_zero", rd, 32'h0);
        check("wr_latency", lat, 3);
        run_cmd(1'b0, 32'h0204, 32'h0, 4'h0, rd, rs, rw, lat);
        check("rd_rdata", rd, 32'hDEADBEEF);
        check("rd_resp", rs, 2'b00);
        check("rd_rsp_write", rw, 1'b0);
        check("rd_latency", lat, 3);

        // partial strobe
        run_cmd(1'b1, 32'h0208, 32'hFFFFFFFF, 4'hF, rd, rs, rw, lat);
        check("preload_resp", rs, 2'b00);
        run_cmd(1'b1, 32'h0208, 32'h00AA5500, 4'b0110, rd, rs, rw, lat);
        check("partial_resp", rs, 2'b10);
        run_cmd(1'b0, 32'h0208, 32'h0, 4'h0, rd, rs, rw, lat);
        check("partial_rb_data", rd, 32'hFFFFFFFF);
        check("partial_rb_resp", rs, 2'b00);

        // invalid address
        run_cmd(1'b1, 32'h0222, 32'h11111111, 4'hF, rd, rs, rw, lat);
        check("bad_wr_resp", rs, 2'b10);
        run_cmd(1'b0, 32'h0222, 32'h0, 4'h0, rd, rs, rw, lat);
        check("bad_rd_resp", rs, 2'b10);
        check("bad_rd_data", rd, 32'h0);

        // skewed AW/W
        aw_delay = 3;
        issue(1'b1, 32'h020C, 32'h12345678, 4'hF);
        aw_cyc = 0; w_cyc = 0; b_first = 0;
        for (int c = 1; c <= 8; c++) begin
            if (awvalid && awaddr == 32'h020C) aw_cyc++;
            if (wvalid && wdata == 32'h12345678) w_cyc++;
            if (bready && b_first == 0) b_first = c;
            @(posedge clk); #1;
        end
        check("skew_aw_cycles", aw_cyc, 4);
        check("skew_w_cycles", w_cyc, 1);
        check("skew_bready_first", b_first, 5);
        check("skew_rsp_valid", rsp_valid, 1'b1);
        check("skew_rsp_write", rsp_write, 1'b1);
        check("skew_resp", rsp_resp, 2'b00);
        rsp_ready = 1'b1; @(posedge clk); #1; rsp_ready = 1'b0;
        aw_delay = 0;
        run_cmd(1'b0, 32'h020C, 32'h0, 4'h0, rd, rs, rw, lat);
        check("skew_readback", rd, 32'h12345678);

        // response backpressure with a queued command
        issue(1'b0, 32'h0204, 32'h0, 4'h0);
        cmd_addr = 32'h0208; cmd_valid = 1'b1;
        n = 0;
        while (!rsp_valid && n < 100) begin @(posedge clk); #1; n++; end
        stable = 0;
        for (int c = 0; c < 5; c++) begin
            if (rsp_valid && rsp_rdata == 32'hDEADBEEF && rsp_resp == 2'b00 && !cmd_ready)
                stable++;
            @(posedge clk); #1;
        end
        check("bp_stable_cycles", stable, 5);
        rsp_ready = 1'b1; @(posedge clk); #1; rsp_ready = 1'b0;
        check("bp_rsp_dropped", rsp_valid, 1'b0);
        check("bp_cmd_ready_back", cmd_ready, 1'b1);
        check("bp_not_yet_issued", arvalid, 1'b0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("bp_queued_arvalid", arvalid, 1'b1);
        check("bp_queued_araddr", araddr, 32'h0208);
        wait_rsp(rd, rs, rw, lat);
        check("bp_queued_rdata", rd, 32'hFFFFFFFF);

        // reset while waiting in RD_DATA
        hold_r = 1'b1;
        issue(1'b0, 32'h0204, 32'h0, 4'h0);
        n = 0;
        while (!rready && n < 100) begin @(posedge clk); #1; n++; end
        check("rst_reached_rd_data", rready, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_valids", {awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 6'b0);
        check("rst_async_rdata", rsp_rdata, 32'h0);
        hold_r = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (rsp_valid) seen++;
            @(posedge clk); #1;
        end
        check("rst_no_rsp", seen, 0);
        check("rst_cmd_ready", cmd_ready, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
